// File: rtl/lfsr_pkg.sv
// -----------------------------------------------------------------------------
// lfsr_pkg
// Shared definitions for the lfsr_prng_burst generator:
//   - lfsr_state_e : control FSM encoding (IDLE / RUN / DONE)
//   - TAPS_4/8/16/32 : maximal-length feedback masks for the left-shifting
//     Fibonacci form used here (bit i set => state[i] feeds the XOR)
//   - SEED_DEFAULT : reset state / replacement for an all-zero seed
// -----------------------------------------------------------------------------
package lfsr_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } lfsr_state_e;

    // Feedback masks: x^4+x^3+1, x^8+x^6+x^5+x^4+1, x^16+x^14+x^13+x^11+1,
    // x^32+x^22+x^2+x+1.
    localparam logic [3:0]  TAPS_4  = 4'hC;
    localparam logic [7:0]  TAPS_8  = 8'hB8;
    localparam logic [15:0] TAPS_16 = 16'hB400;
    localparam logic [31:0] TAPS_32 = 32'h8020_0003;

    localparam logic [15:0] SEED_DEFAULT = 16'hACE1;

endpackage

// File: rtl/lfsr_step_unit.sv
// -----------------------------------------------------------------------------
// lfsr_step_unit
// Purely combinational: advances a Fibonacci LFSR by STEPS shifts.
// One shift: fb = ^(s & TAPS); s = {s[W-2:0], fb}.
// Ports:
//   state_i [W-1:0] : current LFSR state
//   state_o [W-1:0] : state after STEPS chained shifts
// -----------------------------------------------------------------------------
module lfsr_step_unit #(
    parameter int             W     = 16,
    parameter logic [W-1:0]   TAPS  = W'(16'hB400),
    parameter int             STEPS = 1
) (
    input  logic [W-1:0] state_i,
    output logic [W-1:0] state_o
);

    logic [W-1:0] s;

    always_comb begin
        s = state_i;
        for (int i = 0; i < STEPS; i++) begin
            s = {s[W-2:0], ^(s & TAPS)};
        end
        state_o = s;
    end

endmodule

// File: rtl/lfsr_prng_burst.sv
// -----------------------------------------------------------------------------
// lfsr_prng_burst
// Parametrised Fibonacci LFSR word generator with seed load (zero-seed
// guard), finite-burst / free-run modes and a valid/ready output port.
//
// Optional feature macro: LFSR_WRAP_DET_EN
//   defined   : seq_wrap is a sticky flag raised when a generated state equals
//               the state captured at the last seed load (DEFAULT_SEED after
//               reset); cleared by the next honoured seed_load or reset.
//   undefined : seq_wrap is tied low.
//
// Ports:
//   clk          : clock, rising edge
//   rst          : asynchronous active-low reset
//   block_enable : generation enable (low pauses, pending word is held)
//   seed_load    : load seed (IDLE only), seed [W-1:0]
//   start        : begin run (IDLE only), burst_len [CNT_W-1:0] sampled here,
//                  0 = free-run
//   abort        : end run, back to IDLE next cycle, no done pulse
//   out_rand     : random word [OUT_W-1:0], out_valid / out_ready handshake
//   busy         : high in RUN
//   done         : one-cycle pulse after the last word of a finite burst
//   seq_wrap     : sticky period-complete flag
//   dbg_state    : current FSM state
//
// Handshake: a word transfers on a rising edge where out_valid && out_ready.
// While out_valid is high and out_ready is low, out_rand is held stable and
// the LFSR does not advance; a new word may be produced in the same cycle the
// previous one is accepted, giving one word per cycle.
// -----------------------------------------------------------------------------
module lfsr_prng_burst
    import lfsr_pkg::*;
#(
    parameter int           W            = 16,
    parameter int           OUT_W        = 8,
    parameter logic [W-1:0] TAPS         = W'(TAPS_16),
    parameter int           STEPS        = 1,
    parameter logic [W-1:0] DEFAULT_SEED = W'(SEED_DEFAULT),
    parameter int           CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             block_enable,
    input  logic             seed_load,
    input  logic [W-1:0]     seed,
    input  logic             start,
    input  logic [CNT_W-1:0] burst_len,
    input  logic             abort,
    output logic [OUT_W-1:0] out_rand,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             done,
    output logic             seq_wrap,
    output lfsr_state_e      dbg_state
);

    lfsr_state_e      fsm_q,    fsm_d;
    logic [W-1:0]     state_q,  state_d;
    logic [OUT_W-1:0] rand_q,   rand_d;
    logic             valid_q,  valid_d;
    logic [CNT_W-1:0] issued_q, issued_d;
    logic [CNT_W-1:0] blen_q,   blen_d;

    logic [W-1:0]     step_out;
    logic [W-1:0]     loaded_seed;
    logic             load_ok;
    logic             slot_free;
    logic             words_left;
    logic             gen_ev;
    logic             burst_end;

    lfsr_step_unit #(
        .W     (W),
        .TAPS  (TAPS),
        .STEPS (STEPS)
    ) u_step (
        .state_i (state_q),
        .state_o (step_out)
    );

    // An all-zero state would lock the LFSR, so it is never loaded.
    assign loaded_seed = (seed == '0) ? DEFAULT_SEED : seed;
    assign load_ok     = (fsm_q == IDLE) && seed_load;

    // Output slot can take a new word if empty or being drained this cycle.
    assign slot_free  = !valid_q || out_ready;
    assign words_left = (blen_q == '0) || (issued_q < blen_q);
    assign gen_ev     = (fsm_q == RUN) && !abort && block_enable &&
                        slot_free && words_left;
    // Finite burst is complete once all words are issued and none is pending.
    assign burst_end  = (blen_q != '0) && (issued_q == blen_q) && slot_free;

    always_comb begin
        fsm_d    = fsm_q;
        state_d  = state_q;
        rand_d   = rand_q;
        valid_d  = valid_q;
        issued_d = issued_q;
        blen_d   = blen_q;

        case (fsm_q)
            IDLE: begin
                if (load_ok) begin
                    state_d = loaded_seed;
                end
                if (start) begin
                    blen_d   = burst_len;
                    issued_d = '0;
                    fsm_d    = RUN;
                end
            end

            RUN: begin
                if (abort) begin
                    valid_d = 1'b0;
                    fsm_d   = IDLE;
                end else begin
                    if (gen_ev) begin
                        state_d  = step_out;
                        rand_d   = step_out[OUT_W-1:0];
                        valid_d  = 1'b1;
                        // Saturate so a long free run never wraps the count.
                        issued_d = (issued_q == {CNT_W{1'b1}}) ? issued_q
                                                               : issued_q + CNT_W'(1);
                    end else if (valid_q && out_ready) begin
                        valid_d = 1'b0;
                    end
                    if (burst_end) begin
                        fsm_d = DONE;
                    end
                end
            end

            DONE: begin
                fsm_d = IDLE;
            end

            default: begin
                fsm_d   = IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fsm_q    <= IDLE;
            state_q  <= DEFAULT_SEED;
            rand_q   <= '0;
            valid_q  <= 1'b0;
            issued_q <= '0;
            blen_q   <= '0;
        end else begin
            fsm_q    <= fsm_d;
            state_q  <= state_d;
            rand_q   <= rand_d;
            valid_q  <= valid_d;
            issued_q <= issued_d;
            blen_q   <= blen_d;
        end
    end

`ifdef LFSR_WRAP_DET_EN
    logic [W-1:0] ref_q;
    logic         wrap_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ref_q  <= DEFAULT_SEED;
            wrap_q <= 1'b0;
        end else if (load_ok) begin
            ref_q  <= loaded_seed;
            wrap_q <= 1'b0;
        end else if (gen_ev && (step_out == ref_q)) begin
            wrap_q <= 1'b1;
        end
    end

    assign seq_wrap = wrap_q;
`else
    assign seq_wrap = 1'b0;
`endif

    assign out_rand  = rand_q;
    assign out_valid = valid_q;
    assign busy      = (fsm_q == RUN);
    assign done      = (fsm_q == DONE);
    assign dbg_state = fsm_q;

endmodule

// File: tb/tb_lfsr_prng_burst.sv
// -----------------------------------------------------------------------------
// tb_lfsr_prng_burst
// Directed bench for lfsr_prng_burst (default 16/8 configuration) plus a
// 4-bit instance used for the period / seq_wrap check.
// Inputs are driven just after the falling edge; outputs are observed there.
// -----------------------------------------------------------------------------
module tb_lfsr_prng_burst;
    import lfsr_pkg::*;

`ifdef LFSR_WRAP_DET_EN
    localparam bit WRAP_EN = 1'b1;
`else
    localparam bit WRAP_EN = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- main DUT ----------------
    logic        block_enable = 1'b0;
    logic        seed_load    = 1'b0;
    logic [15:0] seed         = '0;
    logic        start        = 1'b0;
    logic [15:0] burst_len    = '0;
    logic        abort        = 1'b0;
    logic        out_ready    = 1'b0;
    logic [7:0]  out_rand;
    logic        out_valid, busy, done, seq_wrap;
    lfsr_state_e dbg_state;

    lfsr_prng_burst dut (
        .clk          (clk),
        .rst          (rst),
        .block_enable (block_enable),
        .seed_load    (seed_load),
        .seed         (seed),
        .start        (start),
        .burst_len    (burst_len),
        .abort        (abort),
        .out_rand     (out_rand),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .busy         (busy),
        .done         (done),
        .seq_wrap     (seq_wrap),
        .dbg_state    (dbg_state)
    );

    // ---------------- 4-bit DUT ----------------
    logic        seed_load4 = 1'b0;
    logic [3:0]  seed4      = '0;
    logic        start4     = 1'b0;
    logic        abort4     = 1'b0;
    logic [3:0]  out_rand4;
    logic        out_valid4, busy4, done4, seq_wrap4;
    lfsr_state_e dbg_state4;

    lfsr_prng_burst #(
        .W            (4),
        .OUT_W        (4),
        .TAPS         (4'hC),
        .STEPS        (1),
        .DEFAULT_SEED (4'h1),
        .CNT_W        (16)
    ) dut4 (
        .clk          (clk),
        .rst          (rst),
        .block_enable (1'b1),
        .seed_load    (seed_load4),
        .seed         (seed4),
        .start        (start4),
        .burst_len    (16'd0),
        .abort        (abort4),
        .out_rand     (out_rand4),
        .out_valid    (out_valid4),
        .out_ready    (1'b1),
        .busy         (busy4),
        .done         (done4),
        .seq_wrap     (seq_wrap4),
        .dbg_state    (dbg_state4)
    );

    // ---------------- scoreboard ----------------
    logic [7:0]  exp_q[$];
    logic [15:0] m;      // reference copy of the 16-bit LFSR state
    logic [3:0]  m4;     // reference copy of the 4-bit LFSR state
    int          vectors     = 0;
    int          miscompares = 0;

    function automatic logic [15:0] model_step(input logic [15:0] s);
        logic fb;
        fb = s[15] ^ s[13] ^ s[12] ^ s[10];
        return {s[14:0], fb};
    endfunction

    function automatic logic [3:0] model_step4(input logic [3:0] s);
        return {s[2:0], s[3] ^ s[2]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic push_word();
        m = model_step(m);
        exp_q.push_back(m[7:0]);
    endtask

    // Checks any word the DUT hands over at the next rising edge, then
    // advances one clock and returns just after the falling edge.
    task automatic clk_cycle();
        logic [7:0] e;
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_word", {24'd0, out_rand}, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                chk("word", {24'd0, out_rand}, {24'd0, e});
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_done(input int max_cycles, input string tag);
        int n = 0;
        while (done !== 1'b1 && n < max_cycles) begin
            clk_cycle();
            n++;
        end
        chk(tag, {31'd0, done}, 32'd1);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_out_rand",  {24'd0, out_rand}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_busy",      {31'd0, busy}, 32'd0);
        chk("rst_done",      {31'd0, done}, 32'd0);
        chk("rst_seq_wrap",  {31'd0, seq_wrap}, 32'd0);
        chk("rst_state",     32'(dbg_state), 32'(IDLE));
        rst = 1'b1;
        @(negedge clk);

        // 1) seed 0x0001 + start burst 4 in the same cycle
        block_enable = 1'b1;
        out_ready    = 1'b1;
        seed_load    = 1'b1;
        seed         = 16'h0001;
        start        = 1'b1;
        burst_len    = 16'd4;
        m            = 16'h0001;
        exp_q.push_back(8'h02);
        exp_q.push_back(8'h04);
        exp_q.push_back(8'h08);
        exp_q.push_back(8'h10);
        m = 16'h0010;
        clk_cycle();
        seed_load = 1'b0;
        start     = 1'b0;
        chk("t1_busy_run", {31'd0, busy}, 32'd1);
        chk("t1_no_valid_yet", {31'd0, out_valid}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            clk_cycle();
            chk("t1_valid_b2b", {31'd0, out_valid}, 32'd1);
        end
        clk_cycle();
        chk("t1_done_pulse", {31'd0, done}, 32'd1);
        chk("t1_busy_low", {31'd0, busy}, 32'd0);
        chk("t1_valid_low", {31'd0, out_valid}, 32'd0);
        clk_cycle();
        chk("t1_done_one_cycle", {31'd0, done}, 32'd0);
        chk("t1_queue_empty", exp_q.size(), 32'd0);

        // 2) zero seed falls back to 0xACE1, one-word burst gives 0xC3
        seed_load = 1'b1;
        seed      = 16'h0000;
        start     = 1'b1;
        burst_len = 16'd1;
        exp_q.push_back(8'hC3);
        m = 16'h59C3;
        clk_cycle();
        seed_load = 1'b0;
        start     = 1'b0;
        clk_cycle();
        chk("t2_zero_seed_word", {24'd0, out_rand}, 32'h0000_00C3);
        wait_done(5, "t2_done");
        clk_cycle();
        chk("t2_queue_empty", exp_q.size(), 32'd0);

        // 3) consumer stall for 5 cycles mid-burst
        start     = 1'b1;
        burst_len = 16'd6;
        for (int i = 0; i < 6; i++) push_word();
        clk_cycle();
        start = 1'b0;
        clk_cycle();
        clk_cycle();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            clk_cycle();
            chk("t3_stall_valid", {31'd0, out_valid}, 32'd1);
            chk("t3_stall_hold", {24'd0, out_rand}, {24'd0, exp_q[0]});
        end
        out_ready = 1'b1;
        wait_done(20, "t3_done");
        chk("t3_queue_empty", exp_q.size(), 32'd0);
        clk_cycle();

        // 4) free-run, block_enable pause, abort with priority over generation
        start     = 1'b1;
        burst_len = 16'd0;
        for (int i = 0; i < 3; i++) push_word();
        clk_cycle();
        start = 1'b0;
        clk_cycle();
        clk_cycle();
        block_enable = 1'b0;
        out_ready    = 1'b0;
        for (int i = 0; i < 3; i++) begin
            clk_cycle();
            chk("t4_pause_valid", {31'd0, out_valid}, 32'd1);
            chk("t4_pause_hold", {24'd0, out_rand}, {24'd0, exp_q[0]});
        end
        out_ready = 1'b1;
        clk_cycle();
        chk("t4_drained", {31'd0, out_valid}, 32'd0);
        clk_cycle();
        chk("t4_paused_idle_slot", {31'd0, out_valid}, 32'd0);
        chk("t4_still_busy", {31'd0, busy}, 32'd1);
        block_enable = 1'b1;
        clk_cycle();
        chk("t4_resume_valid", {31'd0, out_valid}, 32'd1);
        abort = 1'b1;
        clk_cycle();
        abort = 1'b0;
        chk("t4_abort_busy", {31'd0, busy}, 32'd0);
        chk("t4_abort_valid", {31'd0, out_valid}, 32'd0);
        chk("t4_abort_no_done", {31'd0, done}, 32'd0);
        chk("t4_abort_idle", 32'(dbg_state), 32'(IDLE));
        clk_cycle();
        chk("t4_abort_no_done_later", {31'd0, done}, 32'd0);
        chk("t4_queue_empty", exp_q.size(), 32'd0);
        // state retained across abort: next burst continues the sequence
        start     = 1'b1;
        burst_len = 16'd2;
        push_word();
        push_word();
        clk_cycle();
        start = 1'b0;
        wait_done(10, "t4_retained_done");
        chk("t4_retained_queue", exp_q.size(), 32'd0);
        clk_cycle();

        // 5) seed_load/start ignored in RUN, async reset mid-run
        start     = 1'b1;
        burst_len = 16'd3;
        push_word();
        push_word();
        clk_cycle();
        seed_load = 1'b1;
        seed      = 16'h1234;
        burst_len = 16'd1;
        clk_cycle();
        seed_load = 1'b0;
        start     = 1'b0;
        clk_cycle();
        chk("t5_ignored_seed", {24'd0, out_rand}, {24'd0, exp_q[0]});
        #3;
        rst = 1'b0;
        #1;
        chk("t5_rst_out_rand",  {24'd0, out_rand}, 32'd0);
        chk("t5_rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("t5_rst_busy",      {31'd0, busy}, 32'd0);
        chk("t5_rst_done",      {31'd0, done}, 32'd0);
        exp_q.delete();
        m = 16'hACE1;
        @(negedge clk);
        rst = 1'b1;
        start     = 1'b1;
        burst_len = 16'd1;
        push_word();
        clk_cycle();
        start = 1'b0;
        wait_done(10, "t5_after_rst_done");
        chk("t5_after_rst_queue", exp_q.size(), 32'd0);
        chk("t5_main_seq_wrap", {31'd0, seq_wrap}, 32'd0);

        // 6) 4-bit period: seq_wrap after exactly 15 words
        seed_load4 = 1'b1;
        seed4      = 4'h1;
        start4     = 1'b1;
        m4         = 4'h1;
        clk_cycle();
        seed_load4 = 1'b0;
        start4     = 1'b0;
        for (int i = 1; i <= 18; i++) begin
            m4 = model_step4(m4);
            clk_cycle();
            chk("t6_word4", {28'd0, out_rand4}, {28'd0, m4});
            chk("t6_wrap", {31'd0, seq_wrap4}, {31'd0, WRAP_EN && (i >= 15)});
        end
        abort4 = 1'b1;
        clk_cycle();
        abort4 = 1'b0;
        chk("t6_wrap_held_after_abort", {31'd0, seq_wrap4}, {31'd0, WRAP_EN});
        seed_load4 = 1'b1;
        clk_cycle();
        seed_load4 = 1'b0;
        chk("t6_wrap_cleared", {31'd0, seq_wrap4}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
